// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one SRAM-like request/response bus.
// Ports carried: req, wr, size, wstrb, addr, wdata and uncached go from requester to responder.
// addr_ok, data_ok and rdata come back. master = requester side, slave = responder side.
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [DATA_W/8-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              uncached;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  modport master(output req, wr, size, wstrb, addr, wdata, uncached, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, wstrb, addr, wdata, uncached, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data requests onto one memory port, one transfer outstanding.
// Ports: clk, resetn (async active-low).
//   inst = fetch requester (slave; read only).
//   data = data requester (slave).
//   mem = external memory (master).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic resetn,
  mem_arbiter_if.slave inst,
  mem_arbiter_if.slave data,
  mem_arbiter_if.master mem
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t              st;
  logic                last_data;
  logic                owner_data;
  logic                req_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                unc_q;
  logic                grant_data;
  logic                grant_inst;
  logic                unused_ok;
  // On a tie the requester that did not win last time gets the bus.
  assign grant_data = data.req && (!inst.req || !last_data);
  assign grant_inst = inst.req && !grant_data;
  // Grants are gated by resetn so no addr_ok escapes while reset is held.
  assign inst.addr_ok = resetn && st == IDLE && grant_inst;
  assign data.addr_ok = resetn && st == IDLE && grant_data;
  assign inst.data_ok = st == DATA && mem.data_ok && !owner_data;
  assign data.data_ok = st == DATA && mem.data_ok && owner_data;
  assign inst.rdata = mem.rdata;
  assign data.rdata = mem.rdata;
  assign mem.req = req_q;
  assign mem.wr = wr_q;
  assign mem.size = size_q;
  assign mem.wstrb = wstrb_q;
  assign mem.addr = addr_q;
  assign mem.wdata = wdata_q;
  assign mem.uncached = unc_q;
  // The fetch port is read-only; its write-side fields are never used.
  assign unused_ok = ^{inst.wr, inst.size, inst.wstrb, inst.wdata, inst.uncached};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st <= IDLE;
      last_data <= 1'b0;
      owner_data <= 1'b0;
      req_q <= 1'b0;
      wr_q <= 1'b0;
      size_q <= '0;
      wstrb_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      unc_q <= 1'b0;
    end else begin
      case (st)
        IDLE: if (inst.req || data.req) begin
          st <= ADDR;
          req_q <= 1'b1;
          owner_data <= grant_data;
          last_data <= grant_data;
          wr_q <= grant_data && data.wr;
          size_q <= grant_data ? data.size : 2'd2;
          wstrb_q <= grant_data ? data.wstrb : '0;
          addr_q <= grant_data ? data.addr : inst.addr;
          wdata_q <= grant_data ? data.wdata : '0;
          unc_q <= grant_data && data.uncached;
        end
        ADDR: if (mem.addr_ok) begin
          st <= DATA;
          req_q <= 1'b0;
        end
        DATA: if (mem.data_ok) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule
